grey_reader: RTL and testbench
==============================

// Module: grey_reader
// PURPOSE
//  Reading end of the grey-code decimal counter's byte-window port. Steps the 6-bit window select,
//  samples the returned 8-bit window, reassembles 12 grey-coded digits (hunB..ones), decodes each to
//  BCD, flags illegal codes, and presents one 48-bit BCD frame with a valid pulse. Sits in the host
//  or test harness, wired o_sel -> counter io_in[7:2] and counter io_out -> i_data.
// PARAMETERS
//  SETTLE      2  cycles from driving o_sel to sampling i_data (counter output is registered); legal 2..7
//  CONTINUOUS  0  1 = restart a new frame automatically after each o_valid; 0 = one frame per i_start
// PORTS
//  i_clk       in   1   single clock
//  i_rst       in   1   synchronous, active-high reset
//  i_start     in   1   request one frame read; sampled only in IDLE
//  i_data      in   8   window byte from counter
//  o_sel       out  6   window select to counter
//  o_busy      out  1   high from accepted start until o_valid cycle inclusive
//  o_valid     out  1   one-cycle pulse: o_bcd/o_bad/o_xerr hold a complete frame
//  o_bcd       out  48  {hunB,tenB,bil,hunM,tenM,mil,hunT,tenT,thou,hund,tens,ones}, 4 bits each
//  o_bad       out  12  per-digit illegal-code mask, bit 11 = hunB, bit 0 = ones
//  o_zero      out  1   zero flag captured from window 0 bit 7
//  o_xerr      out  1   guard-bit cross-check mismatch (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: o_sel=6'b000000, o_busy=0, o_valid=0, o_bcd=0, o_bad=0, o_zero=0, o_xerr=0, FSM->IDLE.
//    Reset mid-frame aborts; no o_valid for the aborted frame.
//  - Window table, index k=0..11 -> o_sel: 000101,000110,000111,001001,001010,001011,010001,010010,
//    010011,100001,100010,000000. k=0..10: digit k = i_data[6:2]; i_data[7] = zero flag (k=0) or
//    LSB of digit k-1 (k>=1). k=11: ones = i_data[5:1], i_data[7:6] = tens[1:0], i_data[0] = heartbeat.
//  - FSM: IDLE -(i_start)-> DRIVE(k=0); DRIVE holds o_sel=table[k] for SETTLE cycles, then CAPTURE
//    samples i_data on the next edge into digit slot k; CAPTURE -> DRIVE(k+1) or, at k=11, DONE.
//    DONE: o_valid=1 for one cycle, outputs updated that same cycle; -> IDLE, or DRIVE(k=0) if CONTINUOUS.
//  - Frame length = 12*(SETTLE+1)+1 cycles start-to-valid (SETTLE=2: 37). i_start while busy ignored.
//  - Decode (5b->4b): 00000=0,00001=1,00011=2,00010=3,00110=4,00100=5,01100=6,01000=7,11000=8,
//    10000=9; any other code -> nibble 4'hF and o_bad bit set.
//  - o_bcd/o_bad/o_zero/o_xerr hold last frame until next DONE; o_sel returns to 000000 in IDLE.
//  - Frame is not atomic: counter advances during the read; low digits reflect later instants.
// CONFIGURATION
//  GREY_READER_XCHK_EN defined: per window k=1..10, compare i_data[7] with LSB of captured digit k-1;
//    at k=11 compare i_data[7:6] with captured tens[1:0]; any mismatch sets o_xerr for that frame.
//  Not defined: guard bits ignored, o_xerr tied 0, no compare logic synthesised.
// STRUCTURE
//  - Package grey_pkg: SEL_TABLE[12] constants, NUM_DIGITS=12, GREY_W=5, BCD_W=4, grey code
//    constants G0..G9, FSM state enum {IDLE,DRIVE,CAPTURE,DONE}.
//  - Sub-module grey_digit_decode: combinational 5b grey -> {bad,4b bcd}; one instance on the capture
//    path (decode at capture, store BCD + bad bit per slot).
// TESTING
//  - Reset then idle: o_sel=000000, o_valid never asserts, all outputs 0.
//  - Model holds digits 9,8,...,0,1 (hunB..ones), i_start pulse -> o_valid at cycle 37,
//    o_bcd=48'h9876_5432_1001, o_bad=0.
//  - Slot 4 driven 5'b10101 -> o_bcd[31:28]=4'hF, o_bad=12'h080, other nibbles correct.
//  - Assert i_rst at cycle 20 of a frame -> no o_valid, outputs 0, next i_start gives clean frame.
//  - XCHK_EN, window 3 bit 7 flipped -> o_xerr=1; same stimulus without macro -> o_xerr=0.
//  - CONTINUOUS=1, live counter from 0 -> back-to-back o_valid every 37 cycles, ones decodes legal, o_bad=0.

Source files
------------

// File: rtl/grey_reader_pkg.sv
// Shared constants for the grey-code counter reader: window selects, grey code points, FSM states.
package grey_pkg;

  localparam int NUM_DIGITS = 12;
  localparam int GREY_W     = 5;
  localparam int BCD_W      = 4;
  localparam int SEL_W      = 6;
  localparam int K_W        = 4;

  localparam logic [GREY_W-1:0] G0 = 5'b00000;
  localparam logic [GREY_W-1:0] G1 = 5'b00001;
  localparam logic [GREY_W-1:0] G2 = 5'b00011;
  localparam logic [GREY_W-1:0] G3 = 5'b00010;
  localparam logic [GREY_W-1:0] G4 = 5'b00110;
  localparam logic [GREY_W-1:0] G5 = 5'b00100;
  localparam logic [GREY_W-1:0] G6 = 5'b01100;
  localparam logic [GREY_W-1:0] G7 = 5'b01000;
  localparam logic [GREY_W-1:0] G8 = 5'b11000;
  localparam logic [GREY_W-1:0] G9 = 5'b10000;

  // Element k is the counter window select for digit slot k (k=0 is hunB, k=11 is ones).
  localparam logic [NUM_DIGITS-1:0][SEL_W-1:0] SEL_TABLE = {
    6'b000000, 6'b100010, 6'b100001, 6'b010011,
    6'b010010, 6'b010001, 6'b001011, 6'b001010,
    6'b001001, 6'b000111, 6'b000110, 6'b000101
  };

  localparam logic [K_W-1:0] LAST_K = K_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    DONE
  } state_e;

endpackage

// File: rtl/grey_digit_decode.sv
// Combinational 5-bit grey digit to BCD decoder; any non-code point yields 4'hF with o_bad set.
module grey_digit_decode
  import grey_pkg::*;
(
  input  logic [GREY_W-1:0] i_grey,
  output logic [BCD_W-1:0]  o_bcd,
  output logic              o_bad
);

  always_comb begin
    o_bcd = 4'hF;
    o_bad = 1'b0;
    case (i_grey)
      G0:      o_bcd = 4'd0;
      G1:      o_bcd = 4'd1;
      G2:      o_bcd = 4'd2;
      G3:      o_bcd = 4'd3;
      G4:      o_bcd = 4'd4;
      G5:      o_bcd = 4'd5;
      G6:      o_bcd = 4'd6;
      G7:      o_bcd = 4'd7;
      G8:      o_bcd = 4'd8;
      G9:      o_bcd = 4'd9;
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/grey_reader.sv
// Steps the counter's byte window, decodes 12 grey digits and presents a 48-bit BCD frame.
// Optional guard-bit cross-check is enabled by defining GREY_READER_XCHK_EN.
//
// state   | meaning
// IDLE    | o_sel parked at 000000, waiting for i_start
// DRIVE   | o_sel = SEL_TABLE[k], settle down-counter running
// CAPTURE | sample i_data into digit slot k on the next edge
// DONE    | o_valid pulse, frame outputs freshly loaded
module grey_reader
  import grey_pkg::*;
#(
  parameter int SETTLE     = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [7:0]                  i_data,
  output logic [SEL_W-1:0]            o_sel,
  output logic                        o_busy,
  output logic                        o_valid,
  output logic [NUM_DIGITS*BCD_W-1:0] o_bcd,
  output logic [NUM_DIGITS-1:0]       o_bad,
  output logic                        o_zero,
  output logic                        o_xerr
);

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);

  state_e                        state_q, state_d;
  logic [K_W-1:0]                k_q, k_d;
  logic [2:0]                    cnt_q, cnt_d;
  logic [NUM_DIGITS*BCD_W-1:0]   work_bcd_q, work_bcd_d;
  logic [NUM_DIGITS-1:0]         work_bad_q, work_bad_d;
  logic                          work_zero_q, work_zero_d;
  logic [NUM_DIGITS*BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic [NUM_DIGITS-1:0]         out_bad_q, out_bad_d;
  logic                          out_zero_q, out_zero_d;

  logic [GREY_W-1:0]             grey_in;
  logic [BCD_W-1:0]              dec_bcd;
  logic                          dec_bad;
  logic                          unused_heartbeat;

  assign unused_heartbeat = i_data[0];

  // The ones window is shifted down one bit to make room for the tens guard pair.
  assign grey_in = (k_q == LAST_K) ? i_data[5:1] : i_data[6:2];

  grey_digit_decode u_decode (
    .i_grey (grey_in),
    .o_bcd  (dec_bcd),
    .o_bad  (dec_bad)
  );

`ifdef GREY_READER_XCHK_EN
  logic [1:0] prev_grey_q, prev_grey_d;
  logic       work_xerr_q, work_xerr_d;
  logic       out_xerr_q, out_xerr_d;
  logic       guard_err;

  always_comb begin
    guard_err = 1'b0;
    if (k_q == LAST_K) begin
      guard_err = (i_data[7:6] != prev_grey_q);
    end else if (k_q != '0) begin
      guard_err = (i_data[7] != prev_grey_q[0]);
    end
  end

  always_comb begin
    prev_grey_d = prev_grey_q;
    work_xerr_d = work_xerr_q;
    out_xerr_d  = out_xerr_q;
    if ((state_q == IDLE && i_start) || (state_q == DONE && CONTINUOUS != 0)) begin
      work_xerr_d = 1'b0;
    end else if (state_q == CAPTURE) begin
      prev_grey_d = grey_in[1:0];
      work_xerr_d = work_xerr_q | guard_err;
      if (k_q == LAST_K) begin
        out_xerr_d = work_xerr_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_grey_q <= '0;
      work_xerr_q <= 1'b0;
      out_xerr_q  <= 1'b0;
    end else begin
      prev_grey_q <= prev_grey_d;
      work_xerr_q <= work_xerr_d;
      out_xerr_q  <= out_xerr_d;
    end
  end

  assign o_xerr = out_xerr_q;
`else
  assign o_xerr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    work_bcd_d  = work_bcd_q;
    work_bad_d  = work_bad_q;
    work_zero_d = work_zero_q;
    out_bcd_d   = out_bcd_q;
    out_bad_d   = out_bad_q;
    out_zero_d  = out_zero_q;
    o_sel       = '0;
    o_busy      = 1'b0;
    o_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = DRIVE;
          k_d     = '0;
          cnt_d   = SETTLE_LD;
        end
      end

      DRIVE: begin
        o_busy = 1'b1;
        o_sel  = SEL_TABLE[k_q];
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      CAPTURE: begin
        o_busy = 1'b1;
        o_sel  = SEL_TABLE[k_q];
        for (int s = 0; s < NUM_DIGITS; s++) begin
          if (k_q == K_W'(s)) begin
            work_bcd_d[(NUM_DIGITS-1-s)*BCD_W +: BCD_W] = dec_bcd;
            work_bad_d[NUM_DIGITS-1-s]                  = dec_bad;
          end
        end
        if (k_q == '0) begin
          work_zero_d = i_data[7];
        end
        if (k_q == LAST_K) begin
          // Final slot goes straight to the outputs so they are valid in the DONE cycle.
          state_d    = DONE;
          out_bcd_d  = work_bcd_d;
          out_bad_d  = work_bad_d;
          out_zero_d = work_zero_d;
        end else begin
          state_d = DRIVE;
          k_d     = k_q + K_W'(1);
          cnt_d   = SETTLE_LD;
        end
      end

      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (CONTINUOUS != 0) begin
          state_d = DRIVE;
          k_d     = '0;
          cnt_d   = SETTLE_LD;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      work_bcd_q  <= '0;
      work_bad_q  <= '0;
      work_zero_q <= 1'b0;
      out_bcd_q   <= '0;
      out_bad_q   <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      work_bcd_q  <= work_bcd_d;
      work_bad_q  <= work_bad_d;
      work_zero_q <= work_zero_d;
      out_bcd_q   <= out_bcd_d;
      out_bad_q   <= out_bad_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign o_bcd  = out_bcd_q;
  assign o_bad  = out_bad_q;
  assign o_zero = out_zero_q;

endmodule

// File: tb/tb_grey_reader.sv
// Directed bench for grey_reader: registered counter model, one-shot and continuous instances.
module tb_grey_reader;

`ifdef GREY_READER_XCHK_EN
  localparam logic XERR_ON_FLIP = 1'b1;
`else
  localparam logic XERR_ON_FLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_c;
  logic [7:0]  data, data_c;
  logic [5:0]  sel, sel_c;
  logic        busy, busy_c, valid, valid_c, zero, zero_c, xerr, xerr_c;
  logic [47:0] bcd, bcd_c;
  logic [11:0] bad, bad_c;

  int checks = 0;
  int errors = 0;

  logic [4:0] g [12];
  logic [4:0] g_live [12];
  logic       zflag, hb;
  int         flip_k;
  logic [7:0] flip_mask;
  int         live;
  logic       live_en;

  always #5 clk = ~clk;

  grey_reader #(.SETTLE(2), .CONTINUOUS(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(data),
    .o_sel(sel), .o_busy(busy), .o_valid(valid), .o_bcd(bcd),
    .o_bad(bad), .o_zero(zero), .o_xerr(xerr)
  );

  grey_reader #(.SETTLE(2), .CONTINUOUS(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(start_c), .i_data(data_c),
    .o_sel(sel_c), .o_busy(busy_c), .o_valid(valid_c), .o_bcd(bcd_c),
    .o_bad(bad_c), .o_zero(zero_c), .o_xerr(xerr_c)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] enc(input int d);
    case (d)
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b00011;
      3: return 5'b00010;
      4: return 5'b00110;
      5: return 5'b00100;
      6: return 5'b01100;
      7: return 5'b01000;
      8: return 5'b11000;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic int sel_to_k(input logic [5:0] s);
    case (s)
      6'b000101: return 0;
      6'b000110: return 1;
      6'b000111: return 2;
      6'b001001: return 3;
      6'b001010: return 4;
      6'b001011: return 5;
      6'b010001: return 6;
      6'b010010: return 7;
      6'b010011: return 8;
      6'b100001: return 9;
      6'b100010: return 10;
      default:   return 11;
    endcase
  endfunction

  function automatic logic [7:0] window(input logic [5:0] s, input logic [4:0] gg [12],
                                        input logic zf, input logic hbit,
                                        input int fk, input logic [7:0] fm);
    int k;
    logic [7:0] b;
    k = sel_to_k(s);
    if (k == 11) b = {gg[10][1:0], gg[11], hbit};
    else         b = {(k == 0) ? zf : gg[k-1][0], gg[k], 2'b10};
    if (k == fk) b = b ^ fm;
    return b;
  endfunction

  // Counter output is registered: the window byte lags o_sel by one clock.
  always @(posedge clk) begin
    data   <= window(sel, g, zflag, hb, flip_k, flip_mask);
    data_c <= window(sel_c, g_live, 1'b0, hb, -1, 8'h00);
    if (live_en) live <= live + 1;
  end

  always_comb begin
    for (int i = 0; i < 12; i++) begin
      int p;
      p = 1;
      for (int j = 0; j < 11 - i; j++) p = p * 10;
      g_live[i] = enc((live / p) % 10);
    end
  end

  task automatic load_digits(input int d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11);
    g[0] = enc(d0); g[1] = enc(d1); g[2]  = enc(d2);  g[3]  = enc(d3);
    g[4] = enc(d4); g[5] = enc(d5); g[6]  = enc(d6);  g[7]  = enc(d7);
    g[8] = enc(d8); g[9] = enc(d9); g[10] = enc(d10); g[11] = enc(d11);
  endtask

  task automatic run_frame(output int lat);
    int c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1;
    while (valid !== 1'b1 && c < 100) begin
      start = (c == 10);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    lat = c;
  endtask

  task automatic check_after_frame(input string tag);
    check_eq({tag, "_busy_in_valid"}, busy, 1'b1);
    @(negedge clk);
    check_eq({tag, "_valid_pulse"}, valid, 1'b0);
    check_eq({tag, "_sel_idle"}, sel, 6'b000000);
    repeat (3) @(negedge clk);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int lat, nvalid, t0, t1, t2;
    rst = 1'b1; start = 1'b0; start_c = 1'b0;
    zflag = 1'b0; hb = 1'b1; flip_k = -1; flip_mask = 8'h00;
    live = 0; live_en = 1'b0;
    load_digits(9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    nvalid = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    check_eq("rst_sel", sel, 6'b000000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_bcd", bcd, 48'h0);
    check_eq("rst_bad", bad, 12'h000);
    check_eq("rst_zero", zero, 1'b0);
    check_eq("rst_xerr", xerr, 1'b0);
    check_eq("idle_no_valid", nvalid, 0);

    run_frame(lat);
    check_eq("a_latency", lat, 37);
    check_eq("a_bcd", bcd, 48'h9876_5432_1001);
    check_eq("a_bad", bad, 12'h000);
    check_eq("a_zero", zero, 1'b0);
    check_eq("a_xerr", xerr, 1'b0);
    check_after_frame("a");

    g[4] = 5'b10101;
    run_frame(lat);
    check_eq("b_latency", lat, 37);
    check_eq("b_bcd", bcd, 48'h9876_F432_1001);
    check_eq("b_bad", bad, 12'h080);
    check_after_frame("b");

    load_digits(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zflag = 1'b1; hb = 1'b0;
    run_frame(lat);
    check_eq("c_bcd", bcd, 48'h0);
    check_eq("c_bad", bad, 12'h000);
    check_eq("c_zero", zero, 1'b1);

    load_digits(3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8);
    zflag = 1'b0; hb = 1'b1;
    run_frame(lat);
    check_eq("d_bcd", bcd, 48'h3141_5926_5358);
    check_eq("d_zero", zero, 1'b0);
    @(negedge clk);

    // Abort a frame mid-flight with reset.
    load_digits(9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 1);
    zflag = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("abort_bcd", bcd, 48'h0);
    check_eq("abort_bad", bad, 12'h000);
    check_eq("abort_zero", zero, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_sel", sel, 6'b000000);
    nvalid = 0;
    repeat (50) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    check_eq("abort_no_valid", nvalid, 0);
    run_frame(lat);
    check_eq("post_abort_latency", lat, 37);
    check_eq("post_abort_bcd", bcd, 48'h9876_5432_1001);
    check_eq("post_abort_zero", zero, 1'b1);
    @(negedge clk);

    flip_k = 3; flip_mask = 8'h80;
    run_frame(lat);
    check_eq("flip_xerr", xerr, XERR_ON_FLIP);
    check_eq("flip_bcd", bcd, 48'h9876_5432_1001);
    flip_k = -1; flip_mask = 8'h00;
    run_frame(lat);
    check_eq("clean_xerr", xerr, 1'b0);
    @(negedge clk);

    // Continuous instance against a free-running counter.
    live_en = 1'b1;
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    t0 = 1;
    while (valid_c !== 1'b1 && t0 < 100) begin
      @(negedge clk); t0++;
    end
    check_eq("cont_first_latency", t0, 37);
    for (int f = 0; f < 2; f++) begin
      t1 = 0;
      do begin
        @(negedge clk); t1++;
      end while (valid_c !== 1'b1 && t1 < 100);
      check_eq("cont_spacing", t1, 37);
      check_eq("cont_bad", bad_c, 12'h000);
      check_eq("cont_ones_legal", (bcd_c[3:0] <= 4'd9), 1'b1);
      check_eq("cont_high_zero", bcd_c[47:16], 32'h0);
      check_eq("cont_busy", busy_c, 1'b1);
    end
    t2 = 0;
    @(negedge clk);
    check_eq("cont_still_busy", busy_c, 1'b1);
    live_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
